filter_seq: RTL and testbench
=============================

Name: filter_seq

Overview:
Frame-level controller for the 3x3 stream filter. A host loads shadow registers (line width, frame height, 9 kernel taps, rescale, expected result count). On start, the block replays them as a burst on the filter's cfg bus, streams exactly width*height pixels from an upstream valid/ready source into the filter, then counts filter results until the frame drains. It sits between the host/DMA pixel source and the filter's cfg/image ports.

Parameters:
CFG_DWIDTH, 32, filter cfg bus data width
CFG_AWIDTH, 5, filter cfg bus address width
MEM_AWIDTH, 12, line-width/height field width
IMG_WIDTH, 16, pixel width
KER_WIDTH, 16, kernel tap width
KER_NB, 9, number of kernel taps
TIMEOUT, 1024, drain watchdog limit in cycles (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
host_addr  in  4  shadow register address
host_data  in  32  shadow register write data
host_valid  in  1  shadow register write strobe
start  in  1  start-frame pulse
busy  out  1  high from accepted start until done
done  out  1  one-cycle frame-complete pulse
err  out  1  sticky watchdog error (optional feature only; else tied 0)
cfg_data  out  CFG_DWIDTH  to filter cfg_data
cfg_addr  out  CFG_AWIDTH  to filter cfg_addr
cfg_valid  out  1  to filter cfg_valid
up_data  in  IMG_WIDTH  source pixel
up_val  in  1  source valid
up_rdy  out  1  source ready
image  out  IMG_WIDTH  to filter image
image_val  out  1  to filter image_val
result_val  in  1  filter result_val

Behaviour:
- Reset: busy=0, done=0, err=0, cfg_valid=0, cfg_data=0, cfg_addr=0, up_rdy=0, image_val=0, image=0; state IDLE; shadow registers cleared to 0.
- Shadow map: 0 width[MEM_AWIDTH-1:0]; 1 height[MEM_AWIDTH-1:0]; 2..10 tap0..tap8[KER_WIDTH-1:0]; 11 rescale {shift[15:8], head[7:0]}; 12 expected result count [2*MEM_AWIDTH-1:0]. Other addresses ignored. Writes while busy=1 are dropped.
- States: IDLE -> CFG_W -> CFG_K -> CFG_R -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 -> CFG_W next cycle, busy=1. start while busy is ignored.
- CFG_W: one cycle, cfg_valid=1, cfg_addr=1, cfg_data=width (zero-extended).
- CFG_K: KER_NB consecutive cycles, cfg_addr=2, cfg_data=tap0..tap8 in order, zero-extended.
- CFG_R: one cycle, cfg_addr=3, cfg_data={16'b0, shift, head}. cfg_valid=0 in every other state; cfg_data/cfg_addr return to 0.
- First cfg_valid occurs the cycle after start; the burst is exactly 1+KER_NB+1 = 11 back-to-back cycles.
- STREAM: pixel counter loaded with width*height (2*MEM_AWIDTH bits, no truncation). up_rdy=1. A transfer is up_val & up_rdy; image/image_val are registered copies one cycle later. image=0 when image_val=0. On the transfer that takes the counter to 0, up_rdy drops the next cycle and the state moves to DRAIN. If width*height==0, go directly from CFG_R to DRAIN with no transfers.
- DRAIN: count result_val pulses; when count == expected, go to DONE. If expected==0, go to DONE immediately. result_val in IDLE/CFG_*/DONE is ignored; result_val during STREAM is counted.
- DONE: done=1 for one cycle, busy=0 the same cycle, return to IDLE.
- Reset mid-frame: all outputs return to reset values the next cycle, and the frame is abandoned. Shadow registers are cleared.

Optional Feature:
FILTER_SEQ_WATCHDOG_EN: when defined, DRAIN runs a counter that clears on every result_val. If it reaches TIMEOUT, err is set (sticky until rst) and the FSM moves to DONE, so done pulses. When undefined, DRAIN waits indefinitely and err is constant 0.

Test Plan:
- Program width=8, height=4, taps 1..9, rescale shift=4 head=0, expected=12; pulse start -> 11 cfg cycles starting next cycle: (1,8), (2,1)...(2,9), (3,0x0400).
- Same frame, up_val held 1 -> exactly 32 image_val pulses, image equal to up_data delayed 1 cycle, up_rdy low after the 32nd transfer.
- up_val toggling 1/0 every cycle -> still 32 transfers, no extra image_val, and pixel order preserved.
- After streaming, inject 12 result_val -> done pulses once, the cycle after the 12th result is counted; busy falls and a start during busy is ignored.
- height=0, expected=0 -> cfg burst, then done without any up_rdy or image_val.
- With FILTER_SEQ_WATCHDOG_EN and TIMEOUT=16, expected=12 but only 5 results arrive -> err=1 and done pulses 16 cycles after the last result; then rst clears err.

Source files
------------

// File: rtl/filter_seq.sv
// Frame-level sequencer for the 3x3 stream filter: shadow regs -> cfg burst -> pixel stream -> result drain.
// Optional drain watchdog enabled by defining FILTER_SEQ_WATCHDOG_EN.
module filter_seq #(
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned MEM_AWIDTH = 12,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned KER_WIDTH  = 16,
  parameter int unsigned KER_NB     = 9,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            host_addr,
  input  logic [31:0]           host_data,
  input  logic                  host_valid,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic                  cfg_valid,
  input  logic [IMG_WIDTH-1:0]  up_data,
  input  logic                  up_val,
  output logic                  up_rdy,
  output logic [IMG_WIDTH-1:0]  image,
  output logic                  image_val,
  input  logic                  result_val
);

  localparam int unsigned PIX_W  = 2 * MEM_AWIDTH;
  localparam int unsigned KIDX_W = (KER_NB > 1) ? $clog2(KER_NB) : 1;

  localparam logic [3:0] A_WIDTH  = 4'd0;
  localparam logic [3:0] A_HEIGHT = 4'd1;
  localparam logic [3:0] A_TAP0   = 4'd2;
  localparam logic [3:0] A_RESC   = 4'd11;
  localparam logic [3:0] A_EXP    = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_W,
    S_CFG_K,
    S_CFG_R,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  // Host-visible shadow registers
  logic [MEM_AWIDTH-1:0] width_q;
  logic [MEM_AWIDTH-1:0] height_q;
  logic [KER_WIDTH-1:0]  tap_q [KER_NB];
  logic [15:0]           resc_q;
  logic [PIX_W-1:0]      expected_q;

  state_e                state_q, state_d;
  logic [KIDX_W-1:0]     kidx_q, kidx_d;
  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0]      res_cnt_q, res_cnt_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CFG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
  logic [CFG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic                  up_rdy_q, up_rdy_d;
  logic [IMG_WIDTH-1:0]  image_q, image_d;
  logic                  image_val_q, image_val_d;

  logic [PIX_W-1:0]      pix_total_c;
  logic                  xfer_c;
  logic                  res_inc_c;

  assign pix_total_c = PIX_W'(width_q) * PIX_W'(height_q);
  assign xfer_c      = up_val & up_rdy_q;
  assign res_inc_c   = result_val & ((state_q == S_STREAM) | (state_q == S_DRAIN));

`ifdef FILTER_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            unused_bits;
  assign unused_bits = ^host_data[31:24];
  assign err = err_q;
`else
  logic            unused_bits;
  assign unused_bits = ^{host_data[31:24], 1'(TIMEOUT)};
  assign err = 1'b0;
`endif

  // Shadow writes are accepted only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q    <= '0;
      height_q   <= '0;
      resc_q     <= '0;
      expected_q <= '0;
      for (int i = 0; i < KER_NB; i++) tap_q[i] <= '0;
    end else if (host_valid && !busy_q) begin
      if (host_addr == A_WIDTH)  width_q    <= host_data[MEM_AWIDTH-1:0];
      if (host_addr == A_HEIGHT) height_q   <= host_data[MEM_AWIDTH-1:0];
      if (host_addr == A_RESC)   resc_q     <= host_data[15:0];
      if (host_addr == A_EXP)    expected_q <= host_data[PIX_W-1:0];
      for (int i = 0; i < KER_NB; i++) begin
        if (host_addr == 4'(32'(A_TAP0) + 32'(i))) tap_q[i] <= host_data[KER_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kidx_q      <= '0;
      pix_cnt_q   <= '0;
      res_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_data_q  <= '0;
      cfg_addr_q  <= '0;
      cfg_valid_q <= 1'b0;
      up_rdy_q    <= 1'b0;
      image_q     <= '0;
      image_val_q <= 1'b0;
`ifdef FILTER_SEQ_WATCHDOG_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kidx_q      <= kidx_d;
      pix_cnt_q   <= pix_cnt_d;
      res_cnt_q   <= res_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_data_q  <= cfg_data_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_valid_q <= cfg_valid_d;
      up_rdy_q    <= up_rdy_d;
      image_q     <= image_d;
      image_val_q <= image_val_d;
`ifdef FILTER_SEQ_WATCHDOG_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they register alongside it
  always_comb begin
    state_d     = state_q;
    kidx_d      = kidx_q;
    pix_cnt_d   = pix_cnt_q;
    res_cnt_d   = res_inc_c ? (res_cnt_q + PIX_W'(1)) : res_cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cfg_data_d  = '0;
    cfg_addr_d  = '0;
    cfg_valid_d = 1'b0;
    up_rdy_d    = 1'b0;
    image_d     = '0;
    image_val_d = 1'b0;
`ifdef FILTER_SEQ_WATCHDOG_EN
    wd_d        = '0;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CFG_W;
          kidx_d    = '0;
          res_cnt_d = '0;
        end
      end
      S_CFG_W: begin
        state_d = S_CFG_K;
        kidx_d  = '0;
      end
      S_CFG_K: begin
        if (kidx_q == KIDX_W'(KER_NB - 1)) state_d = S_CFG_R;
        else                               kidx_d  = kidx_q + KIDX_W'(1);
      end
      S_CFG_R: begin
        pix_cnt_d = pix_total_c;
        res_cnt_d = '0;
        state_d   = (pix_total_c == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        if (xfer_c) begin
          pix_cnt_d = pix_cnt_q - PIX_W'(1);
          if (pix_cnt_q == PIX_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_cnt_d >= expected_q) begin
          state_d = S_DONE;
        end
`ifdef FILTER_SEQ_WATCHDOG_EN
        // wd_q holds cycles elapsed since the last result (or DRAIN entry)
        else if (result_val) begin
          wd_d = WD_W'(1);
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d   = (state_d == S_DONE);
    up_rdy_d = (state_d == S_STREAM);

    case (state_d)
      S_CFG_W: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CFG_AWIDTH'(1);
        cfg_data_d  = CFG_DWIDTH'(width_q);
      end
      S_CFG_K: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CFG_AWIDTH'(2);
        cfg_data_d  = CFG_DWIDTH'(tap_q[kidx_d]);
      end
      S_CFG_R: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CFG_AWIDTH'(3);
        cfg_data_d  = CFG_DWIDTH'(resc_q);
      end
      default: begin
        cfg_valid_d = 1'b0;
      end
    endcase

    if (xfer_c) begin
      image_val_d = 1'b1;
      image_d     = up_data;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_valid = cfg_valid_q;
  assign up_rdy    = up_rdy_q;
  assign image     = image_q;
  assign image_val = image_val_q;

endmodule

// File: tb/tb_filter_seq.sv
// Directed self-checking bench for filter_seq: cfg burst, streaming, drain, zero-size frame, reset, watchdog.
module tb_filter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  host_addr;
  logic [31:0] host_data;
  logic        host_valid;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic [15:0] up_data;
  logic        up_val;
  logic        up_rdy;
  logic [15:0] image;
  logic        image_val;
  logic        result_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  filter_seq #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .host_valid (host_valid),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cfg_data   (cfg_data),
    .cfg_addr   (cfg_addr),
    .cfg_valid  (cfg_valid),
    .up_data    (up_data),
    .up_val     (up_val),
    .up_rdy     (up_rdy),
    .image      (image),
    .image_val  (image_val),
    .result_val (result_val)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then stable for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [31:0] d);
    host_addr  = a;
    host_data  = d;
    host_valid = 1'b1;
    step();
    host_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int sent;
    bit exp_x;

    rst = 1'b1; host_addr = '0; host_data = '0; host_valid = 1'b0; start = 1'b0;
    up_data = '0; up_val = 1'b0; result_val = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cfg_valid", 32'(cfg_valid), 0);
    check("rst_cfg_data", cfg_data, 0);
    check("rst_cfg_addr", 32'(cfg_addr), 0);
    check("rst_up_rdy", 32'(up_rdy), 0);
    check("rst_image_val", 32'(image_val), 0);
    check("rst_image", 32'(image), 0);
    rst = 1'b0;
    step();

    // Frame 1: 8x4, taps 1..9, shift=4 head=0, expected 12
    host_wr(4'd0, 32'd8);
    host_wr(4'd1, 32'd4);
    for (int k = 0; k < 9; k++) host_wr(4'(2 + k), 32'(k + 1));
    host_wr(4'd11, 32'h0000_0400);
    host_wr(4'd12, 32'd12);
    check("idle_busy", 32'(busy), 0);

    pulse_start();
    check("f1_cfgw_valid", 32'(cfg_valid), 1);
    check("f1_cfgw_addr", 32'(cfg_addr), 1);
    check("f1_cfgw_data", cfg_data, 8);
    check("f1_busy", 32'(busy), 1);
    for (int k = 0; k < 9; k++) begin
      start = (k == 3);
      step();
      check("f1_cfgk_valid", 32'(cfg_valid), 1);
      check("f1_cfgk_addr", 32'(cfg_addr), 2);
      check("f1_cfgk_data", cfg_data, 32'(k + 1));
    end
    start = 1'b0;
    step();
    check("f1_cfgr_valid", 32'(cfg_valid), 1);
    check("f1_cfgr_addr", 32'(cfg_addr), 3);
    check("f1_cfgr_data", cfg_data, 32'h0400);
    step();
    check("f1_post_cfg_valid", 32'(cfg_valid), 0);
    check("f1_post_cfg_addr", 32'(cfg_addr), 0);
    check("f1_post_cfg_data", cfg_data, 0);
    check("f1_stream_rdy", 32'(up_rdy), 1);
    check("f1_stream_ival0", 32'(image_val), 0);

    // up_val held high; a host write in flight must be dropped
    host_addr = 4'd0;
    host_data = 32'd5;
    for (int i = 0; i < 32; i++) begin
      up_val     = 1'b1;
      up_data    = 16'(16'h0100 + i);
      host_valid = (i == 5);
      step();
      check("f1_ival", 32'(image_val), 1);
      check("f1_image", 32'(image), 32'(16'h0100 + i));
      check("f1_up_rdy", 32'(up_rdy), 32'(i < 31));
    end
    host_valid = 1'b0;
    up_data = 16'hdead;
    for (int i = 0; i < 3; i++) begin
      step();
      check("f1_extra_ival", 32'(image_val), 0);
      check("f1_extra_image", 32'(image), 0);
      check("f1_rdy_low", 32'(up_rdy), 0);
    end
    up_val = 1'b0;

    for (int r = 0; r < 12; r++) begin
      result_val = 1'b1;
      step();
      check("f1_done", 32'(done), 32'(r == 11));
      check("f1_busy_drain", 32'(busy), 32'(r != 11));
    end
    result_val = 1'b0;
    step();
    check("f1_done_once", 32'(done), 0);
    check("f1_idle_busy", 32'(busy), 0);

    // Frame 2: toggling up_val, 6 results arrive during streaming
    pulse_start();
    check("f2_cfgw_data_wr_dropped", cfg_data, 8);
    for (int k = 0; k < 10; k++) step();
    check("f2_cfgr_addr", 32'(cfg_addr), 3);
    check("f2_cfgr_data", cfg_data, 32'h0400);
    step();
    sent = 0;
    for (int c = 0; c < 70; c++) begin
      up_val     = (c % 2 == 0);
      up_data    = 16'(16'h0200 + c);
      result_val = (c < 6);
      exp_x      = up_val && (sent < 32);
      step();
      check("f2_ival", 32'(image_val), 32'(exp_x));
      check("f2_image", 32'(image), exp_x ? 32'(16'h0200 + c) : 32'd0);
      if (exp_x) sent++;
      check("f2_up_rdy", 32'(up_rdy), 32'(sent < 32));
      check("f2_no_done", 32'(done), 0);
    end
    up_val = 1'b0;
    result_val = 1'b0;
    for (int r = 0; r < 6; r++) begin
      result_val = 1'b1;
      step();
      check("f2_done", 32'(done), 32'(r == 5));
    end
    result_val = 1'b0;
    step();
    check("f2_done_once", 32'(done), 0);
    check("f2_busy_idle", 32'(busy), 0);

    // Frame 3: zero height, zero expected
    host_wr(4'd1, 32'd0);
    host_wr(4'd12, 32'd0);
    up_val = 1'b1;
    up_data = 16'h7777;
    pulse_start();
    check("f3_cfgw_valid", 32'(cfg_valid), 1);
    for (int k = 0; k < 10; k++) begin
      step();
      check("f3_cfg_valid", 32'(cfg_valid), 1);
      check("f3_no_rdy", 32'(up_rdy), 0);
    end
    check("f3_cfgr_addr", 32'(cfg_addr), 3);
    step();
    check("f3_drain_cfg_valid", 32'(cfg_valid), 0);
    check("f3_drain_rdy", 32'(up_rdy), 0);
    check("f3_drain_ival", 32'(image_val), 0);
    check("f3_drain_done", 32'(done), 0);
    step();
    check("f3_done", 32'(done), 1);
    check("f3_busy", 32'(busy), 0);
    check("f3_done_ival", 32'(image_val), 0);
    step();
    check("f3_done_once", 32'(done), 0);
    up_val = 1'b0;

    // Reset in the middle of streaming clears outputs and shadow registers
    host_wr(4'd1, 32'd4);
    pulse_start();
    for (int k = 0; k < 11; k++) step();
    check("rm_stream_rdy", 32'(up_rdy), 1);
    up_val = 1'b1;
    up_data = 16'h0abc;
    step();
    check("rm_ival", 32'(image_val), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    up_val = 1'b0;
    check("rm_busy", 32'(busy), 0);
    check("rm_up_rdy", 32'(up_rdy), 0);
    check("rm_ival_clr", 32'(image_val), 0);
    check("rm_image_clr", 32'(image), 0);
    check("rm_cfg_valid", 32'(cfg_valid), 0);
    check("rm_done", 32'(done), 0);
    pulse_start();
    check("rm_cfgw_valid", 32'(cfg_valid), 1);
    check("rm_width_cleared", cfg_data, 0);
    step();
    check("rm_tap0_cleared", cfg_data, 0);
    wait_done("rm_empty_frame_done", 30);
    step();

`ifdef FILTER_SEQ_WATCHDOG_EN
    // Watchdog: 1x4 frame, expected 12, only 5 results arrive
    host_wr(4'd0, 32'd1);
    host_wr(4'd1, 32'd4);
    host_wr(4'd12, 32'd12);
    pulse_start();
    for (int k = 0; k < 11; k++) step();
    up_val = 1'b1;
    for (int i = 0; i < 4; i++) step();
    up_val = 1'b0;
    check("wd_rdy_low", 32'(up_rdy), 0);
    for (int r = 0; r < 5; r++) begin
      result_val = 1'b1;
      step();
    end
    result_val = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      check("wd_done", 32'(done), 32'(k == 15));
      check("wd_err", 32'(err), 32'(k == 15));
    end
    step();
    check("wd_done_once", 32'(done), 0);
    check("wd_err_sticky", 32'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wd_err_rst", 32'(err), 0);
`else
    check("err_tied_low", 32'(err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
